// File: rtl/pixel_scheduler_if.sv
// Handshake bundle between the pixel scheduler, its two iteration engines and the pixel sink.
interface pixel_scheduler_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ITER_W = 8
) ();
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic [1:0]          res_valid;
  logic [1:0]          res_ready;
  logic [2*ITER_W-1:0] res_iter;
  logic                pix_valid;
  logic                pix_ready;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [7:0]          pix_r;
  logic [7:0]          pix_g;
  logic [7:0]          pix_b;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    output pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
    input  req_ready, res_valid, res_iter, pix_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    input  pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
    output req_ready, res_valid, res_iter, pix_ready
  );
endinterface

// File: rtl/pixel_scheduler.sv
// Raster-order pixel dispatcher over two iteration engines with round-robin result collection and colour mapping.
// Optional frame cycle statistics under SCHED_STATS_EN; frame_cycles is tied to 0 otherwise.
module pixel_scheduler #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  output logic [31:0]         frame_cycles,
  pixel_scheduler_if.master   bus
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t         state, state_n;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [1:0]     eng_busy, eng_busy_n;
  logic [X_W-1:0] tag_x [2];
  logic [Y_W-1:0] tag_y [2];
  logic           off_vld, off_vld_n;
  logic           off_eng, off_eng_n;
  logic           disp_ptr, disp_ptr_n;
  logic           res_ptr;
  logic           xfer, last_pix;
  logic [1:0]     cand;
  logic           res_any, res_eng, res_acc, out_free;
  logic [ITER_W-1:0] iter_sel;
  logic [7:0]     it8, col_r, col_g, col_b;

  logic           pix_vld_q;
  logic [X_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic [7:0]     pix_r_q, pix_g_q, pix_b_q;

  assign xfer     = off_vld && bus.req_ready[off_eng];
  assign last_pix = (x_q == X_W'(H_RES - 1)) && (y_q == Y_W'(V_RES - 1));
  assign out_free = !pix_vld_q || bus.pix_ready;
  assign cand     = bus.res_valid & eng_busy;

  assign busy          = (state != IDLE);
  assign frame_done    = (state == DONE);
  assign bus.req_valid = off_vld ? (2'b01 << off_eng) : 2'b00;
  assign bus.req_x     = x_q;
  assign bus.req_y     = y_q;
  assign bus.res_ready = res_acc ? (2'b01 << res_eng) : 2'b00;
  assign bus.pix_valid = pix_vld_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_r     = pix_r_q;
  assign bus.pix_g     = pix_g_q;
  assign bus.pix_b     = pix_b_q;

  // Result arbitration: res_ptr names the engine preferred next.
  always_comb begin
    res_any = 1'b0;
    res_eng = res_ptr;
    if (cand[res_ptr]) begin
      res_any = 1'b1;
      res_eng = res_ptr;
    end else if (cand[~res_ptr]) begin
      res_any = 1'b1;
      res_eng = ~res_ptr;
    end
    res_acc = res_any && out_free;
  end

  always_comb begin
    iter_sel = res_eng ? bus.res_iter[2*ITER_W-1:ITER_W] : bus.res_iter[ITER_W-1:0];
    it8      = iter_sel[7:0];
    col_r    = 8'h00;
    col_g    = 8'h00;
    col_b    = 8'h00;
    if (iter_sel < ITER_W'(MAX_ITER)) begin
      col_r = it8;
      col_g = {it8[6:0], 1'b0};
      col_b = 8'hFF - it8;
    end
  end

  // The offer is registered so req_valid and coordinates cannot move while waiting for req_ready.
  always_comb begin
    state_n    = state;
    eng_busy_n = eng_busy;
    disp_ptr_n = disp_ptr;
    off_vld_n  = 1'b0;
    off_eng_n  = off_eng;
    if (res_acc) eng_busy_n[res_eng] = 1'b0;
    if (xfer) begin
      eng_busy_n[off_eng] = 1'b1;
      disp_ptr_n          = ~off_eng;
    end
    case (state)
      IDLE:     if (start) state_n = DISPATCH;
      DISPATCH: if (xfer && last_pix) state_n = DRAIN;
      DRAIN:    if (eng_busy == 2'b00 && !pix_vld_q) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (state_n == DISPATCH) begin
      if (off_vld && !xfer) begin
        off_vld_n = 1'b1;
      end else if (!eng_busy_n[disp_ptr_n]) begin
        off_vld_n = 1'b1;
        off_eng_n = disp_ptr_n;
      end else if (!eng_busy_n[~disp_ptr_n]) begin
        off_vld_n = 1'b1;
        off_eng_n = ~disp_ptr_n;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      eng_busy <= 2'b00;
      off_vld  <= 1'b0;
      off_eng  <= 1'b0;
      disp_ptr <= 1'b0;
      res_ptr  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      tag_x[0] <= '0;
      tag_x[1] <= '0;
      tag_y[0] <= '0;
      tag_y[1] <= '0;
    end else begin
      state    <= state_n;
      eng_busy <= eng_busy_n;
      off_vld  <= off_vld_n;
      off_eng  <= off_eng_n;
      disp_ptr <= disp_ptr_n;
      if (res_acc) res_ptr <= ~res_eng;
      if (state == IDLE && start) begin
        x_q <= '0;
        y_q <= '0;
      end else if (state == DISPATCH && xfer) begin
        tag_x[off_eng] <= x_q;
        tag_y[off_eng] <= y_q;
        if (x_q == X_W'(H_RES - 1)) begin
          x_q <= '0;
          y_q <= y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_vld_q <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      pix_r_q   <= 8'h00;
      pix_g_q   <= 8'h00;
      pix_b_q   <= 8'h00;
    end else if (res_acc) begin
      pix_vld_q <= 1'b1;
      pix_x_q   <= tag_x[res_eng];
      pix_y_q   <= tag_y[res_eng];
      pix_r_q   <= col_r;
      pix_g_q   <= col_g;
      pix_b_q   <= col_b;
    end else if (bus.pix_ready) begin
      pix_vld_q <= 1'b0;
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] cyc_q;

  // The start-acceptance cycle counts as the first cycle of the frame.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cyc_q <= 32'd0;
    end else if (state == IDLE && start) begin
      cyc_q <= 32'd1;
    end else if (state != IDLE) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign frame_cycles = cyc_q;
`else
  assign frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Randomized bench for pixel_scheduler on a 4x2 frame with behavioural engines and a pixel scoreboard.
module tb_pixel_scheduler;
  localparam int H = 4, V = 2, XW = 10, YW = 9, IW = 8, MI = 255;

  logic        aclk = 1'b0;
  logic        aresetn, start, busy, frame_done;
  logic [31:0] frame_cycles;

  pixel_scheduler_if #(.X_W(XW), .Y_W(YW), .ITER_W(IW)) bus ();

  pixel_scheduler #(.H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW), .ITER_W(IW), .MAX_ITER(MI)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy),
    .frame_done(frame_done), .frame_cycles(frame_cycles), .bus(bus.master)
  );

  always #5 aclk = ~aclk;

  int n_assert = 0, n_fail = 0;
  logic [1:0] eb;
  int eit[2], ewait[2];
  int lat_lo = 0, lat_hi = 0, rdy_pct = 100, pr_pct = 100, stall_left = 0;
  bit start_now = 0, rst_val = 0;
  int disp_n, pix_n, done_cnt, cyc = 0, cs = 0, cd = 0, rr_next;
  int exp_iter[H*V], seen[H*V];
  logic pv_prev, pr_prev, rx_prev;
  logic [1:0] rv_prev;
  logic [XW+YW+23:0] pd_prev;
  logic [XW+YW-1:0]  rq_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] colour(input int it);
    if (it >= MI) return 24'h0;
    return {8'(it), 8'((it * 2) % 256), 8'(255 - it)};
  endfunction

  task automatic model_reset();
    eb = 2'b00;
    for (int i = 0; i < 2; i++) begin eit[i] = 0; ewait[i] = 0; end
    rr_next = 0;
    pv_prev = 1'b0;
    rv_prev = 2'b00;
  endtask

  task automatic board_reset();
    disp_n = 0; pix_n = 0; done_cnt = 0;
    for (int k = 0; k < H*V; k++) begin seen[k] = 0; exp_iter[k] = -1; end
  endtask

  task automatic cycle();
    logic [1:0] cand, exp_rr, just;
    logic acc;
    int idx, pick;
    @(negedge aclk);
    aresetn = rst_val;
    start   = start_now;
    for (int i = 0; i < 2; i++) begin
      bus.req_ready[i] = !eb[i] && ($urandom_range(99) < rdy_pct);
      bus.res_valid[i] = eb[i] && (ewait[i] == 0);
    end
    bus.res_iter = {IW'(eit[1]), IW'(eit[0])};
    if (stall_left > 0) begin bus.pix_ready = 1'b0; stall_left--; end
    else bus.pix_ready = ($urandom_range(99) < pr_pct);
    #1;
    if (!aresetn) begin
      chk("reset_outputs", |{busy, frame_done, bus.req_valid, bus.res_ready, bus.pix_valid, bus.pix_x,
          bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b, frame_cycles, bus.req_x, bus.req_y}, 0);
    end else begin
      if (pv_prev && !pr_prev)
        chk("pix_hold", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b}, {1'b1, pd_prev});
      if (rv_prev != 2'b00 && !rx_prev)
        chk("req_hold", {bus.req_valid, bus.req_x, bus.req_y}, {rv_prev, rq_prev});
      chk("req_onehot", $countones(bus.req_valid) <= 1, 1);
      chk("req_to_free", bus.req_valid & eb, 0);
      cand   = bus.res_valid & eb;
      acc    = !bus.pix_valid || bus.pix_ready;
      exp_rr = 2'b00;
      if (acc && cand != 2'b00) begin
        pick = cand[rr_next] ? rr_next : 1 - rr_next;
        exp_rr[pick] = 1'b1;
      end
      chk("res_ready", bus.res_ready, exp_rr);
    end
    if (bus.pix_valid && bus.pix_ready) begin
      idx = int'(bus.pix_y) * H + int'(bus.pix_x);
      chk("pix_in_frame", (bus.pix_x < H) && (bus.pix_y < V) && (idx < disp_n), 1);
      if (bus.pix_x < H && bus.pix_y < V) begin
        chk("pix_once", seen[idx], 0);
        seen[idx]++;
        chk("pix_colour", {bus.pix_r, bus.pix_g, bus.pix_b}, colour(exp_iter[idx]));
        if (idx == 0) chk("rgb_iter16", {bus.pix_r, bus.pix_g, bus.pix_b}, 24'h1020EF);
        if (idx == 1) chk("rgb_maxiter", {bus.pix_r, bus.pix_g, bus.pix_b}, 24'h000000);
      end
      pix_n++;
    end
    for (int i = 0; i < 2; i++)
      if (bus.res_valid[i] && bus.res_ready[i]) begin eb[i] = 1'b0; rr_next = 1 - i; end
    just = 2'b00;
    for (int i = 0; i < 2; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        chk("req_raster", {bus.req_x, bus.req_y}, {XW'(disp_n % H), YW'(disp_n / H)});
        eb[i]    = 1'b1;
        just[i]  = 1'b1;
        eit[i]   = (disp_n == 0) ? 16 : (disp_n == 1) ? MI : int'($urandom_range(MI));
        ewait[i] = int'($urandom_range(lat_hi, lat_lo));
        if (disp_n < H*V) exp_iter[disp_n] = eit[i];
        disp_n++;
      end
    for (int i = 0; i < 2; i++)
      if (eb[i] && !just[i] && ewait[i] > 0) ewait[i]--;
    if (frame_done) begin done_cnt++; cd = cyc; end
    if (start && !busy && aresetn) cs = cyc;
    pv_prev = bus.pix_valid;
    pr_prev = bus.pix_ready;
    pd_prev = {bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b};
    rv_prev = bus.req_valid;
    rx_prev = |(bus.req_valid & bus.req_ready);
    rq_prev = {bus.req_x, bus.req_y};
    cyc++;
  endtask

  task automatic run_frame(input string tag, input bit do_stall);
    int t, distinct;
    bit stalled;
    board_reset();
    start_now = 1'b1;
    cycle();
    start_now = 1'b0;
    t = 0;
    stalled = 1'b0;
    while (!(done_cnt > 0 && !busy) && t < 2000) begin
      if (do_stall && !stalled && disp_n >= 3) begin stall_left = 10; stalled = 1'b1; end
      cycle();
      t++;
    end
    distinct = 0;
    for (int k = 0; k < H*V; k++) if (seen[k] == 1) distinct++;
    chk({tag, "_timeout"}, t < 2000, 1);
    chk({tag, "_pix_count"}, pix_n, H*V);
    chk({tag, "_each_once"}, distinct, H*V);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_low"}, busy, 0);
`ifdef SCHED_STATS_EN
    chk({tag, "_frame_cycles"}, frame_cycles, 32'(cd - cs + 1));
`else
    chk({tag, "_frame_cycles"}, frame_cycles, 0);
`endif
  endtask

  initial begin
    int t;
    aresetn = 1'b0;
    start = 1'b0;
    bus.req_ready = 2'b00;
    bus.res_valid = 2'b00;
    bus.res_iter = '0;
    bus.pix_ready = 1'b0;
    model_reset();
    board_reset();
    rst_val = 1'b0;
    repeat (3) cycle();
    rst_val = 1'b1;
    cycle();
    chk("idle_busy", busy, 0);

    lat_lo = 0; lat_hi = 0; rdy_pct = 100; pr_pct = 100;
    run_frame("basic", 1'b0);

    lat_lo = 0; lat_hi = 4; rdy_pct = 60; pr_pct = 70;
    run_frame("random", 1'b0);

    lat_lo = 1; lat_hi = 2; rdy_pct = 100; pr_pct = 100;
    run_frame("stall", 1'b1);

    lat_lo = 3; lat_hi = 3; rdy_pct = 50; pr_pct = 100;
    board_reset();
    start_now = 1'b1;
    cycle();
    start_now = 1'b0;
    t = 0;
    while (disp_n < 3 && t < 500) begin cycle(); t++; end
    chk("abort_reached", disp_n >= 3, 1);
    chk("abort_no_done", done_cnt, 0);
    model_reset();
    rst_val = 1'b0;
    repeat (2) cycle();
    rst_val = 1'b1;
    cycle();
    chk("abort_idle", busy, 0);

    lat_lo = 0; lat_hi = 3; rdy_pct = 80; pr_pct = 80;
    run_frame("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
